// File: rtl/uart_rx.sv
// 8N1 UART receiver timed by an external OVERSAMPLE x baud tick (rx_en).
// Samples mid-bit on the synchronized line and emits one-cycle valid/error pulses.
`timescale 1ns/1ps

module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       RxD,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0]   FULL_LAST = TW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic          rxd_meta_q, rxd_s_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    // Synchronizer flops reset to the idle (high) line level so reset never looks like a START edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
        end else begin
            rxd_meta_q <= RxD;
            rxd_s_q    <= rxd_meta_q;
        end
    end

    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (rx_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!rxd_s_q) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end
                S_START: begin
                    if (tick_q == HALF_LAST) begin
                        tick_d  = '0;
                        bit_d   = 3'd0;
                        state_d = rxd_s_q ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_q == FULL_LAST) begin
                        shreg_d = {rxd_s_q, shreg_q[7:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_q == FULL_LAST) begin
                        tick_d = '0;
                        if (rxd_s_q) begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_err   = err_q;
    assign rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of good frames plus hand sequences for
// glitch, framing error/break, mid-frame reset and a full byte loopback sweep.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_en;
    logic       RxD;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       rx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_div = 65;
    int valid_cnt = 0;
    int err_cnt   = 0;

    typedef struct {
        logic [7:0] data;
        int         tdiv;
        int         idle_bits;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_en    (rx_en),
        .RxD      (RxD),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rx_busy  (rx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        wait_clks(OS * tick_div);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    // Oversampling tick: one clock high every tick_div clocks.
    initial begin
        int tc;
        tc    = 0;
        rx_en = 1'b0;
        forever begin
            @(negedge clk);
            if (tc >= tick_div - 1) begin
                rx_en = 1'b1;
                tc    = 0;
            end else begin
                rx_en = 1'b0;
                tc++;
            end
        end
    end

    // Pulse monitor: counts pulses, checks exclusivity and single-cycle width.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_valid === 1'b1 || rx_err === 1'b1)
                check("valid_err_exclusive", 32'(rx_valid & rx_err), 32'd0);
            if (rx_valid === 1'b1) begin
                check("valid_one_cycle", 32'(prev_v), 32'd0);
                valid_cnt++;
            end
            if (rx_err === 1'b1) err_cnt++;
            prev_v = rx_valid;
        end
    end

    initial begin
        int  v0, e0, fall_at;
        logic seen_busy;

        vecs[0] = '{8'h55, 65, 1, 8'h55};
        vecs[1] = '{8'hA3, 4, 2, 8'hA3};
        vecs[2] = '{8'h0F, 4, 0, 8'h0F};

        rst_n = 1'b0;
        RxD   = 1'b1;
        wait_clks(3);
        check("reset_data",  32'(rx_data),  32'd0);
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_err",   32'(rx_err),   32'd0);
        check("reset_busy",  32'(rx_busy),  32'd0);
        rst_n = 1'b1;

        // Single byte at 65-clock ticks, then back-to-back 0xA3 / 0x0F.
        for (int i = 0; i < 3; i++) begin
            tick_div = vecs[i].tdiv;
            for (int k = 0; k < vecs[i].idle_bits; k++) send_bit(1'b1);
            v0 = valid_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].data, 1'b1);
            check("vec_valid", 32'(valid_cnt - v0), 32'd1);
            check("vec_err",   32'(err_cnt - e0),   32'd0);
            check("vec_data",  32'(rx_data),        32'(vecs[i].exp_data));
            check("vec_busy",  32'(rx_busy),        32'd0);
        end

        // Glitch: low for 4 ticks only.
        tick_div = 4;
        send_bit(1'b1);
        v0 = valid_cnt;
        e0 = err_cnt;
        seen_busy = 1'b0;
        fall_at   = -1;
        RxD = 1'b0;
        for (int k = 0; k < 4 * tick_div; k++) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
        end
        RxD = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rx_busy) seen_busy = 1'b1;
            else if (seen_busy && fall_at < 0) fall_at = k;
        end
        check("glitch_busy_rise", 32'(seen_busy), 32'd1);
        check("glitch_busy_fall", 32'(fall_at >= 0 && fall_at <= 40), 32'd1);
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_err",   32'(err_cnt - e0),   32'd0);
        check("glitch_data",  32'(rx_data),        32'h0F);

        // Framing error followed by 3 bit times of break, then a good frame.
        send_bit(1'b1);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h00, 1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b0);
        check("break_err",   32'(err_cnt - e0),   32'd1);
        check("break_valid", 32'(valid_cnt - v0), 32'd0);
        check("break_data",  32'(rx_data),        32'h0F);
        check("break_busy",  32'(rx_busy),        32'd1);
        send_bit(1'b1);
        check("break_exit_busy", 32'(rx_busy), 32'd0);
        send_frame(8'h7E, 1'b1);
        check("after_break_valid", 32'(valid_cnt - v0), 32'd1);
        check("after_break_err",   32'(err_cnt - e0),   32'd1);
        check("after_break_data",  32'(rx_data),        32'h7E);

        // Reset during bit 3 of 0xC6; the transmitter aborts to idle as well.
        send_bit(1'b1);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        RxD = 1'b0;
        wait_clks(OS * tick_div / 2);
        rst_n = 1'b0;
        RxD   = 1'b1;
        #1;
        check("midrst_data",  32'(rx_data),  32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_err",   32'(rx_err),   32'd0);
        check("midrst_busy",  32'(rx_busy),  32'd0);
        wait_clks(2);
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        check("midrst_no_pulse", 32'(valid_cnt - v0 + err_cnt - e0), 32'd0);
        check("midrst_idle_busy", 32'(rx_busy), 32'd0);
        send_frame(8'h3C, 1'b1);
        check("midrst_valid_after", 32'(valid_cnt - v0), 32'd1);
        check("midrst_data_after",  32'(rx_data),        32'h3C);

        // Loopback sweep, back-to-back, tick on every clock.
        tick_div = 1;
        send_bit(1'b1);
        v0 = valid_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b1);
            check("loop_data", 32'(rx_data), 32'(i));
        end
        check("loop_valid_cnt", 32'(valid_cnt - v0), 32'd256);
        check("loop_err_cnt",   32'(err_cnt - e0),   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the downstream counterpart of the UART TX path. It consumes an asynchronous 8N1 serial stream on `RxD` (idle high, START = 0, 8 data bits LSB first, STOP = 1) and delivers each received byte as a one-cycle-valid parallel word. Timing comes from an external oversampling tick `rx_en`, produced by the same style of tick generator that drives the TX baud-rate tick, but running at OVERSAMPLE × baud.

## Interface

- `OVERSAMPLE`, default 16: number of `rx_en` ticks per bit period. Must be even and ≥ 4.
- `clk` in 1: on-board 100 MHz system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rx_en` in 1: single-clock-pulse tick, asserted OVERSAMPLE times per bit (153.6 kHz for 9600 baud at the default).
- `RxD` in 1: asynchronous serial input.
- `rx_data` out 8: last correctly framed byte. Held until the next good frame.
- `rx_valid` out 1: one-clock pulse when `rx_data` is updated.
- `rx_err` out 1: one-clock pulse on a framing error (STOP sampled as 0).
- `rx_busy` out 1: high whenever the FSM is not in IDLE.

## Operation

- **Input synchronizer.** `RxD` passes through a 2-flop synchronizer (both flops reset to 1) to produce `rxd_s`. All decisions use `rxd_s`.
- **Counters.**
  - `tick_cnt`: $clog2(OVERSAMPLE) bits. Increments only on `rx_en`.
  - `bit_cnt`: 3 bits.
- **Shift register.** `shreg[7:0]`. Each sample shifts right, with the new bit entering `shreg[7]`, so the byte is LSB-first aligned after 8 samples.
- **FSM states and transitions:**
  - **IDLE**: on an `rx_en` tick with `rxd_s` = 0, go to START and clear `tick_cnt`. Otherwise stay.
  - **START**: on each `rx_en`, increment `tick_cnt`. On the tick where `tick_cnt` = OVERSAMPLE/2−1 (mid START bit), sample `rxd_s`:
    - 0: go to DATA; clear `tick_cnt` and `bit_cnt`.
    - 1: false start (glitch); go back to IDLE. No output pulse.
  - **DATA**: on each `rx_en`, increment `tick_cnt`. On the tick where `tick_cnt` = OVERSAMPLE−1 (mid-bit), shift `rxd_s` into `shreg`, clear `tick_cnt`, and increment `bit_cnt`. After the 8th sample (`bit_cnt` was 7), go to STOP.
  - **STOP**: on the tick where `tick_cnt` = OVERSAMPLE−1, sample `rxd_s`:
    - 1: load `rx_data` ← `shreg`, pulse `rx_valid`, go to IDLE.
    - 0: pulse `rx_err`, leave `rx_data` unchanged, go to BREAK.
  - **BREAK**: stay until an `rx_en` tick sees `rxd_s` = 1, then go to IDLE. This prevents a held-low line from retriggering frames.
- `rx_en` pulses are ignored outside the tick on which they occur. Any `rx_en` duty and any `RxD` value are legal at all times.
- `rx_valid` and `rx_err` are never high in the same cycle.

## Timing

- **Reset values:**
  - FSM = IDLE; `tick_cnt` = 0; `bit_cnt` = 0; `shreg` = 0.
  - Both synchronizer flops = 1.
  - `rx_data` = 8'h00; `rx_valid` = 0; `rx_err` = 0; `rx_busy` = 0.
- **Reset mid-frame:** the partial frame is discarded and the outputs return to their reset values immediately (asynchronous). Reception restarts at the next falling edge of the line seen in IDLE.
- **Input latency:** 2 clocks from `RxD` to `rxd_s`. Start detection happens on the first `rx_en` tick after `rxd_s` falls.
- **Output latency:** `rx_valid` and `rx_err` are registered. They are high exactly for the clock cycle following the `rx_en` cycle that samples STOP. `rx_data` changes in that same cycle.
- **`rx_busy`:**
  - Rises the cycle after the START-detect tick.
  - Falls the cycle after the transition to IDLE.
  - Stays high throughout BREAK.
- **Sample points:** the START sample lands OVERSAMPLE/2 ticks after the edge. Each following sample lands OVERSAMPLE ticks after the previous one. The result is mid-bit sampling with ±OVERSAMPLE/2 ticks of margin.
- **Back-to-back frames:** after STOP is sampled, the FSM returns to IDLE. A START edge arriving within the remaining half STOP bit is detected on the next tick. No minimum idle time is required.
- **Counter wrap:** `tick_cnt` is cleared explicitly at every sample point and never wraps freely. `bit_cnt` wraps 7 → 0 on the STOP transition.

## Test plan

1. **Single byte.** Set `rx_en` every 65 clocks and send 0x55 (8N1). Required: one `rx_valid` pulse, `rx_data` = 8'h55, `rx_err` never high, `rx_busy` low after the frame.
2. **Back-to-back bytes.** Send 0xA3 then 0x0F with zero idle time. Required: two `rx_valid` pulses, with `rx_data` = 8'hA3 and then 8'h0F.
3. **Glitch rejection.** Drive `RxD` low for 4 ticks, then high. Required: `rx_busy` pulses high, then returns to 0 at the mid-START tick; no `rx_valid`, no `rx_err`; `rx_data` unchanged.
4. **Framing error and break.** Send 0x00 with STOP = 0 and hold the line low for 3 more bit times, then release it and send 0x7E. Required:
   - Exactly one `rx_err` pulse.
   - `rx_data` stays at its prior value during the break.
   - No retrigger while the line is low.
   - Then `rx_valid` fires with `rx_data` = 8'h7E.
5. **Reset mid-frame.** Assert `rst_n` = 0 during bit 3 of 0xC6 for 2 clocks, then send 0x3C. Required: all outputs are at their reset values during reset, no pulse for the aborted frame, and `rx_data` = 8'h3C afterwards.
6. **Loopback.** Drive a byte sweep 0x00–0xFF from the TX path at 9600 baud with a 16× `rx_en`. Required: 256 `rx_valid` pulses, every received byte equal to the sent byte, zero `rx_err`.
